// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder
//   Registered binary-to-one-hot decoder with an internal index counter.
//   The index can be loaded directly from sel, or stepped up/down once
//   every DIV enabled cycles. The one-hot output can be blanked without
//   losing the index. Every output comes straight from a flop.
//
// Parameters
//   N   : index width; y is 2**N bits wide (N >= 1)
//   DIV : scan prescaler period in enabled cycles (DIV >= 1)
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en       in   global enable; 0 freezes idx, prescaler, y and stored mode
//   mode     in   00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 BLANK
//   sel      in   index loaded when load = 1
//   load     in   load strobe (ignored when en = 0)
//   y        out  one-hot of idx, or all-zero in BLANK
//   idx      out  current index
//   wrap     out  one-cycle pulse on the cycle a scan step wrapped idx
//
// Handshake: none. Inputs are sampled on every rising edge where en = 1;
// there is no valid/ready pairing, load is a single-cycle strobe.
module onehot_scan_decoder #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        sel,
  input  logic                load,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int W  = 1 << N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]  IDX_MAX    = {N{1'b1}};

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_BLANK     = 2'b11
  } mode_e;

  logic [N-1:0]  idx_q,   idx_d;
  logic [W-1:0]  y_q,     y_d;
  logic          wrap_q,  wrap_d;
  logic [PW-1:0] presc_q, presc_d;
  mode_e         prev_mode_q, prev_mode_d;
  mode_e         mode_in;

  assign mode_in = mode_e'(mode);

  always_comb begin
    idx_d       = idx_q;
    y_d         = y_q;
    wrap_d      = 1'b0;     // wrap is a pulse: low unless a wrapping step happens
    presc_d     = presc_q;
    prev_mode_d = prev_mode_q;

    if (en) begin
      prev_mode_d = mode_in;

      if (load) begin
        idx_d   = sel;
        presc_d = '0;
      end else if (mode_in != prev_mode_q) begin
        // A mode change restarts the period so the next step is a full DIV away.
        presc_d = '0;
      end else if (mode_in == MODE_SCAN_UP || mode_in == MODE_SCAN_DOWN) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (mode_in == MODE_SCAN_UP) begin
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == IDX_MAX);
          end else begin
            idx_d  = idx_q - 1'b1;
            wrap_d = (idx_q == '0);
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end else begin
        presc_d = '0;
      end

      // y is decoded from the next index so it lines up with idx on the same edge.
      y_d = '0;
      if (mode_in != MODE_BLANK) begin
        y_d[idx_d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      y_q         <= W'(1);
      wrap_q      <= 1'b0;
      presc_q     <= '0;
      prev_mode_q <= MODE_DIRECT;
    end else begin
      idx_q       <= idx_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
      presc_q     <= presc_d;
      prev_mode_q <= prev_mode_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
